// File: rtl/fc_layer_load_sequencer.sv
// -----------------------------------------------------------------------------
// fc_layer_load_sequencer
//
// Fills one fully-connected neuron layer's value register bank from a
// valid/ready input stream. A start request first clears the layer with a
// single layer_reset pulse. Accepted beats are then written to consecutive
// addresses 0..tgt-1, and a one-cycle done pulse follows. The target count is
// num_values, clamped to LAYER_SZ.
//
// Optional build macro: FC_LOAD_ZERO_SKIP_EN
//   When defined, an accepted beat whose value is zero still advances the
//   index and counts toward the target, but issues no write. This is safe
//   because the layer was cleared in CLEAR.
//
// Parameters
//   SIZE      data width of a neuron value and width of the address port
//   LAYER_SZ  number of neurons in the driven layer
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   start         one-cycle load request, honoured only in IDLE
//   num_values    beats to load, sampled when start is accepted
//   abort         synchronous cancel of an in-progress load
//   in_valid      upstream beat valid
//   in_value      upstream beat data
//   in_ready      combinational: high while in LOAD
//   layer_reset   neuron layer synchronous clear (registered)
//   load_en       neuron layer write enable (registered)
//   load_address  neuron layer write address, zero-extended index (registered)
//   load_value    neuron layer write data (registered)
//   busy          high in any state other than IDLE (registered)
//   done          one-cycle pulse coincident with the final write (registered)
// -----------------------------------------------------------------------------
module fc_layer_load_sequencer #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 84,
    localparam int CNT_W   = $clog2(LAYER_SZ + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_values,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [SIZE-1:0]  in_value,
    output logic             in_ready,
    output logic             layer_reset,
    output logic             load_en,
    output logic [SIZE-1:0]  load_address,
    output logic [SIZE-1:0]  load_value,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAYER_SZ_C = CNT_W'(LAYER_SZ);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [CNT_W-1:0]  index_r;
    logic [CNT_W-1:0]  tgt_r;
    logic [CNT_W-1:0]  tgt_clamped_s;

    logic              start_ok_s;
    logic              accept_s;
    logic              last_s;
    logic              write_s;

    logic              layer_reset_r;
    logic              load_en_r;
    logic [SIZE-1:0]   load_address_r;
    logic [SIZE-1:0]   load_value_r;
    logic              busy_r;
    logic              done_r;

    logic              layer_reset_next_s;
    logic              load_en_next_s;
    logic [SIZE-1:0]   load_address_next_s;
    logic [SIZE-1:0]   load_value_next_s;
    logic              busy_next_s;
    logic              done_next_s;

    // in_ready is the only combinational output; abort still suppresses the
    // acceptance even though in_ready stays high in that cycle.
    assign in_ready = (state_r == ST_LOAD);

    // Handshake and target qualification shared by the FSM and the datapath.
    always_comb begin
        start_ok_s    = start && !abort;
        accept_s      = (state_r == ST_LOAD) && in_valid && !abort;
        // tgt_r is at least 1 whenever LOAD is reachable, so tgt_r-1 cannot wrap.
        last_s        = accept_s && (index_r == (tgt_r - CNT_ONE_C));
        if (num_values > LAYER_SZ_C) begin
            tgt_clamped_s = LAYER_SZ_C;
        end else begin
            tgt_clamped_s = num_values;
        end
`ifdef FC_LOAD_ZERO_SKIP_EN
        // A zero beat needs no write: the bank already holds zero after CLEAR.
        write_s       = accept_s && (in_value != {SIZE{1'b0}});
`else
        write_s       = accept_s;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; abort has priority over every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (tgt_r == CNT_ZERO_C) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs. The
    // state-derived outputs look at the next state, so each one is high
    // during the state it belongs to.
    always_comb begin
        layer_reset_next_s = (state_next_s == ST_CLEAR);
        done_next_s        = (state_next_s == ST_DONE);
        busy_next_s        = (state_next_s != ST_IDLE);
        load_en_next_s     = write_s;
        if (write_s) begin
            load_address_next_s = SIZE'(index_r);
            load_value_next_s   = in_value;
        end else begin
            load_address_next_s = load_address_r;
            load_value_next_s   = load_value_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_reset_r  <= 1'b0;
            load_en_r      <= 1'b0;
            load_address_r <= {SIZE{1'b0}};
            load_value_r   <= {SIZE{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            layer_reset_r  <= layer_reset_next_s;
            load_en_r      <= load_en_next_s;
            load_address_r <= load_address_next_s;
            load_value_r   <= load_value_next_s;
            busy_r         <= busy_next_s;
            done_r         <= done_next_s;
        end
    end

    // Index and target count. The index goes back to zero on the final beat,
    // so it never reaches LAYER_SZ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_r <= CNT_ZERO_C;
            tgt_r   <= CNT_ZERO_C;
        end else if ((state_r == ST_IDLE) && start_ok_s) begin
            index_r <= CNT_ZERO_C;
            tgt_r   <= tgt_clamped_s;
        end else if (abort && (state_r != ST_IDLE)) begin
            index_r <= CNT_ZERO_C;
            tgt_r   <= tgt_r;
        end else if (accept_s) begin
            if (last_s) begin
                index_r <= CNT_ZERO_C;
            end else begin
                index_r <= index_r + CNT_ONE_C;
            end
            tgt_r <= tgt_r;
        end else begin
            index_r <= index_r;
            tgt_r   <= tgt_r;
        end
    end

    assign layer_reset  = layer_reset_r;
    assign load_en      = load_en_r;
    assign load_address = load_address_r;
    assign load_value   = load_value_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_fc_layer_load_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for fc_layer_load_sequencer (SIZE=16, LAYER_SZ=84).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge. A passive monitor logs writes, done and layer_reset
// pulses with their cycle numbers. Each test task compares the log against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fc_layer_load_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  num_values;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_value;
    logic        in_ready;
    logic        layer_reset;
    logic        load_en;
    logic [15:0] load_address;
    logic [15:0] load_value;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    // monitor log (monotonic counters; tests snapshot bases)
    int wr_n, done_n, lr_n, ir_n, ovl_n, hi_n, cyc;
    int done_cyc, lr_cyc;
    int wr_addr [512];
    int wr_val  [512];
    int wr_cyc  [512];
    int wb, db, lb, ib;

    fc_layer_load_sequencer #(.SIZE(16), .LAYER_SZ(84)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_values   (num_values),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_value     (in_value),
        .in_ready     (in_ready),
        .layer_reset  (layer_reset),
        .load_en      (load_en),
        .load_address (load_address),
        .load_value   (load_value),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (load_en === 1'b1) begin
            if (wr_n < 512) begin
                wr_addr[wr_n] <= int'(load_address);
                wr_val[wr_n]  <= int'(load_value);
                wr_cyc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
        if (done === 1'b1) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (layer_reset === 1'b1) begin
            lr_n   <= lr_n + 1;
            lr_cyc <= cyc;
        end
        if (in_ready === 1'b1) ir_n <= ir_n + 1;
        if (layer_reset === 1'b1 && load_en === 1'b1) ovl_n <= ovl_n + 1;
        if (load_address[15:7] !== 9'd0) hi_n <= hi_n + 1;
    end

    task automatic clear_log();
        wb = wr_n; db = done_n; lb = lr_n; ib = ir_n;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue start; returns 1 unit after the edge that moves the DUT into CLEAR.
    task automatic do_start(input logic [6:0] n);
        start = 1'b1;
        num_values = n;
        tick(1);
        start = 1'b0;
    endtask

    // Present one beat and hold it until in_ready is seen before a rising edge.
    task automatic send_beat(input logic [15:0] v);
        logic acc;
        int   waited;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_value = v;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            tick(1);
            waited++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: beat %0h not accepted within 50 cycles", v);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL rst_load_en: got %b want 0", load_en); end
        n_checks++; if (layer_reset !== 1'b0) begin n_fail++; $display("FAIL rst_layer_reset: got %b want 0", layer_reset); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (load_address !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", load_address); end
        n_checks++; if (load_value !== 16'h0000) begin n_fail++; $display("FAIL rst_value: got %h want 0000", load_value); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // start together with abort in IDLE: nothing may start
        start = 1'b1; abort = 1'b1; num_values = 7'd3;
        tick(1);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b want 0", busy); end
        n_checks++; if (layer_reset !== 1'b0) begin n_fail++; $display("FAIL start_abort_clear: got %b want 0", layer_reset); end
        tick(1);
    endtask

    task automatic test_back_to_back();
        clear_log();
        do_start(7'd3);
        @(negedge clk);
        n_checks++; if (layer_reset !== 1'b1) begin n_fail++; $display("FAIL b2b_clear: got %b want 1", layer_reset); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_clear: got %b want 0", in_ready); end
        send_beat(16'd5);
        send_beat(16'd7);
        send_beat(16'd9);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
        n_checks++; if (load_en !== 1'b1) begin n_fail++; $display("FAIL b2b_last_en: got %b want 1", load_en); end
        n_checks++; if (load_address !== 16'd2) begin n_fail++; $display("FAIL b2b_last_addr: got %0d want 2", load_address); end
        n_checks++; if (load_value !== 16'd9) begin n_fail++; $display("FAIL b2b_last_value: got %0d want 9", load_value); end
        tick(1);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_after: got %b want 0", done); end
        tick(1);
        n_checks++; if (wr_n - wb != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", wr_n - wb); end
        if (wr_n - wb == 3) begin
            n_checks++; if (wr_addr[wb] != 0 || wr_val[wb] != 5) begin n_fail++; $display("FAIL b2b_w0: got %0d=%0d want 0=5", wr_addr[wb], wr_val[wb]); end
            n_checks++; if (wr_addr[wb+1] != 1 || wr_val[wb+1] != 7) begin n_fail++; $display("FAIL b2b_w1: got %0d=%0d want 1=7", wr_addr[wb+1], wr_val[wb+1]); end
            n_checks++; if (wr_addr[wb+2] != 2 || wr_val[wb+2] != 9) begin n_fail++; $display("FAIL b2b_w2: got %0d=%0d want 2=9", wr_addr[wb+2], wr_val[wb+2]); end
            n_checks++; if (wr_cyc[wb+1] != wr_cyc[wb] + 1 || wr_cyc[wb+2] != wr_cyc[wb] + 2) begin n_fail++; $display("FAIL b2b_consecutive: got cycles %0d %0d %0d", wr_cyc[wb], wr_cyc[wb+1], wr_cyc[wb+2]); end
            n_checks++; if (done_cyc != wr_cyc[wb+2]) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want %0d", done_cyc, wr_cyc[wb+2]); end
            n_checks++; if (wr_cyc[wb] != lr_cyc + 2) begin n_fail++; $display("FAIL b2b_latency: got first write at %0d want %0d", wr_cyc[wb], lr_cyc + 2); end
        end
        n_checks++; if (lr_n - lb != 1) begin n_fail++; $display("FAIL b2b_clear_count: got %0d want 1", lr_n - lb); end
        n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_n - db); end
    endtask

    task automatic test_stall();
        logic [6:0] pat;
        int exp_val [4];
        pat = 7'b1011001;   // bit i is in_valid in LOAD cycle i
        exp_val[0] = 16'h10; exp_val[1] = 16'h13; exp_val[2] = 16'h14; exp_val[3] = 16'h16;
        clear_log();
        do_start(7'd4);
        tick(1);
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_value = 16'h0010 + 16'(i);
            if (i == 1) begin start = 1'b1; num_values = 7'd1; end
            if (i == 2) start = 1'b0;
            tick(1);
        end
        in_valid = 1'b0;
        tick(3);
        n_checks++; if (wr_n - wb != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", wr_n - wb); end
        if (wr_n - wb == 4) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (wr_addr[wb+k] != k || wr_val[wb+k] != exp_val[k]) begin
                    n_fail++; $display("FAIL stall_w%0d: got %0d=%0h want %0d=%0h", k, wr_addr[wb+k], wr_val[wb+k], k, exp_val[k]);
                end
            end
            n_checks++;
            if (wr_cyc[wb+1] - wr_cyc[wb] != 3 || wr_cyc[wb+2] - wr_cyc[wb+1] != 1 || wr_cyc[wb+3] - wr_cyc[wb+2] != 2) begin
                n_fail++; $display("FAIL stall_gaps: got cycles %0d %0d %0d %0d want gaps 3,1,2", wr_cyc[wb], wr_cyc[wb+1], wr_cyc[wb+2], wr_cyc[wb+3]);
            end
            n_checks++; if (done_cyc != wr_cyc[wb+3]) begin n_fail++; $display("FAIL stall_done_cycle: got %0d want %0d", done_cyc, wr_cyc[wb+3]); end
        end
        n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", done_n - db); end
        n_checks++; if (lr_n - lb != 1) begin n_fail++; $display("FAIL stall_clear_count: got %0d want 1", lr_n - lb); end
    endtask

    task automatic test_empty();
        clear_log();
        in_valid = 1'b1;
        in_value = 16'h0055;
        do_start(7'd0);
        @(negedge clk);
        n_checks++; if (layer_reset !== 1'b1) begin n_fail++; $display("FAIL empty_clear: got %b want 1", layer_reset); end
        tick(1);
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", done); end
        n_checks++; if (layer_reset !== 1'b0) begin n_fail++; $display("FAIL empty_clear_len: got %b want 0", layer_reset); end
        tick(1);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle: got %b want 0", busy); end
        in_valid = 1'b0;
        tick(1);
        n_checks++; if (wr_n - wb != 0) begin n_fail++; $display("FAIL empty_writes: got %0d want 0", wr_n - wb); end
        n_checks++; if (ir_n - ib != 0) begin n_fail++; $display("FAIL empty_ready: got %0d ready cycles want 0", ir_n - ib); end
        n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL empty_done_count: got %0d want 1", done_n - db); end
        n_checks++; if (done_cyc != lr_cyc + 1) begin n_fail++; $display("FAIL empty_done_cycle: got %0d want %0d", done_cyc, lr_cyc + 1); end
    endtask

    task automatic test_overflow();
        clear_log();
        do_start(7'd100);
        for (int k = 0; k < 84; k++) send_beat(16'h0200 + 16'(k));
        in_value = 16'hffff;   // keep in_valid high: nothing more may be taken
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b want 1", done); end
        n_checks++; if (load_address !== 16'd83) begin n_fail++; $display("FAIL ovf_last_addr: got %0d want 83", load_address); end
        tick(1);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got ready=%b busy=%b want 0 0", in_ready, busy); end
        in_valid = 1'b0;
        tick(2);
        n_checks++; if (wr_n - wb != 84) begin n_fail++; $display("FAIL ovf_count: got %0d want 84", wr_n - wb); end
        if (wr_n - wb == 84) begin
            for (int k = 0; k < 84; k++) begin
                n_checks++;
                if (wr_addr[wb+k] != k || wr_val[wb+k] != 16'h0200 + k) begin
                    n_fail++; $display("FAIL ovf_w%0d: got %0d=%0h want %0d=%0h", k, wr_addr[wb+k], wr_val[wb+k], k, 16'h0200 + k);
                end
            end
        end
        n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL ovf_done_count: got %0d want 1", done_n - db); end
    endtask

    task automatic test_abort();
        clear_log();
        do_start(7'd5);
        send_beat(16'h0031);
        send_beat(16'h0032);
        abort = 1'b1;
        in_valid = 1'b1;
        in_value = 16'h0033;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", in_ready); end
        tick(1);
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", busy); end
        n_checks++; if (load_en !== 1'b0) begin n_fail++; $display("FAIL abort_no_write: got %b want 0", load_en); end
        tick(3);
        n_checks++; if (wr_n - wb != 2) begin n_fail++; $display("FAIL abort_count: got %0d want 2", wr_n - wb); end
        if (wr_n - wb == 2) begin
            n_checks++; if (wr_addr[wb] != 0 || wr_val[wb] != 16'h31 || wr_addr[wb+1] != 1 || wr_val[wb+1] != 16'h32) begin
                n_fail++; $display("FAIL abort_writes: got %0d=%0h %0d=%0h want 0=31 1=32", wr_addr[wb], wr_val[wb], wr_addr[wb+1], wr_val[wb+1]);
            end
        end
        n_checks++; if (done_n - db != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_n - db); end
        // a fresh start after abort must run normally from address 0
        clear_log();
        do_start(7'd1);
        send_beat(16'h0044);
        in_valid = 1'b0;
        tick(2);
        n_checks++; if (wr_n - wb != 1) begin n_fail++; $display("FAIL restart_count: got %0d want 1", wr_n - wb); end
        if (wr_n - wb == 1) begin
            n_checks++; if (wr_addr[wb] != 0 || wr_val[wb] != 16'h44) begin n_fail++; $display("FAIL restart_write: got %0d=%0h want 0=44", wr_addr[wb], wr_val[wb]); end
        end
        n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", done_n - db); end
    endtask

    task automatic test_async_reset();
        do_start(7'd5);
        send_beat(16'h0001);
        send_beat(16'h0002);
        in_value = 16'h0003;   // in_valid stays high
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (load_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL arst_ctrl: got en=%b busy=%b ready=%b want 0 0 0", load_en, busy, in_ready);
        end
        n_checks++; if (load_address !== 16'h0000 || load_value !== 16'h0000) begin
            n_fail++; $display("FAIL arst_data: got addr=%h value=%h want 0000 0000", load_address, load_value);
        end
        n_checks++; if (done !== 1'b0 || layer_reset !== 1'b0) begin n_fail++; $display("FAIL arst_pulses: got done=%b clr=%b want 0 0", done, layer_reset); end
        clear_log();
        tick(1);
        reset = 1'b0;
        tick(4);
        in_valid = 1'b0;
        n_checks++; if (wr_n - wb != 0) begin n_fail++; $display("FAIL arst_writes: got %0d want 0", wr_n - wb); end
        n_checks++; if (done_n - db != 0) begin n_fail++; $display("FAIL arst_done: got %0d want 0", done_n - db); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_skip();
        clear_log();
        do_start(7'd3);
        send_beat(16'h0000);
        send_beat(16'h0004);
        send_beat(16'h0000);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zs_done: got %b want 1", done); end
        tick(2);
`ifdef FC_LOAD_ZERO_SKIP_EN
        n_checks++; if (wr_n - wb != 1) begin n_fail++; $display("FAIL zs_count: got %0d want 1", wr_n - wb); end
        if (wr_n - wb == 1) begin
            n_checks++; if (wr_addr[wb] != 1 || wr_val[wb] != 4) begin n_fail++; $display("FAIL zs_write: got %0d=%0d want 1=4", wr_addr[wb], wr_val[wb]); end
        end
`else
        n_checks++; if (wr_n - wb != 3) begin n_fail++; $display("FAIL zs_count: got %0d want 3", wr_n - wb); end
        if (wr_n - wb == 3) begin
            n_checks++; if (wr_addr[wb] != 0 || wr_val[wb] != 0) begin n_fail++; $display("FAIL zs_w0: got %0d=%0d want 0=0", wr_addr[wb], wr_val[wb]); end
            n_checks++; if (wr_addr[wb+1] != 1 || wr_val[wb+1] != 4) begin n_fail++; $display("FAIL zs_w1: got %0d=%0d want 1=4", wr_addr[wb+1], wr_val[wb+1]); end
            n_checks++; if (wr_addr[wb+2] != 2 || wr_val[wb+2] != 0) begin n_fail++; $display("FAIL zs_w2: got %0d=%0d want 2=0", wr_addr[wb+2], wr_val[wb+2]); end
        end
`endif
        n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL zs_done_count: got %0d want 1", done_n - db); end
    endtask

    task automatic test_invariants();
        n_checks++; if (ovl_n != 0) begin n_fail++; $display("FAIL clear_write_overlap: got %0d cycles want 0", ovl_n); end
        n_checks++; if (hi_n != 0) begin n_fail++; $display("FAIL addr_upper_bits: got %0d cycles nonzero want 0", hi_n); end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        num_values = 7'd0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_value = 16'h0000;
        n_checks = 0; n_fail = 0;
        wr_n = 0; done_n = 0; lr_n = 0; ir_n = 0; ovl_n = 0; hi_n = 0; cyc = 0;
        done_cyc = 0; lr_cyc = 0;
        wb = 0; db = 0; lb = 0; ib = 0;

        test_reset();
        test_back_to_back();
        test_stall();
        test_empty();
        test_overflow();
        test_abort();
        test_async_reset();
        test_zero_skip();
        test_invariants();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_load_sequencer.md
Name: fc_layer_load_sequencer

Overview:
Sequences the filling of one fully-connected neuron layer's value register bank from a valid/ready input stream. On `start` it clears the layer, then writes accepted values to consecutive addresses 0..N-1 and signals `done`. It sits between the upstream producer (memory reader or previous-layer MAC) and the neuron layer's load_en/load_address/load_value/reset port group.

Parameters:
SIZE, 16, data width of each neuron value and width of the layer address port
LAYER_SZ, 84, number of neurons in the driven layer; internal CNT_W = $clog2(LAYER_SZ+1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a layer load; honoured only in IDLE
num_values  input  CNT_W  beats to load; sampled on an accepted start
abort  input  1  synchronous cancel of an in-progress load
in_valid  input  1  upstream beat valid
in_value  input  SIZE  upstream beat data
in_ready  output  1  sequencer can accept a beat this cycle
layer_reset  output  1  drives the neuron layer's synchronous reset
load_en  output  1  neuron layer write enable
load_address  output  SIZE  neuron layer write address, zero-extended index
load_value  output  SIZE  neuron layer write data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last write is issued

Behaviour:
- Reset (async) -> state IDLE; all outputs 0; index and target count 0.
- All outputs are registered except in_ready, which equals (state==LOAD) combinationally.
- States:
  - IDLE: start=1 -> latch tgt = min(num_values, LAYER_SZ), index=0, go CLEAR.
  - CLEAR: layer_reset=1 for exactly one cycle. If tgt==0 go DONE, else go LOAD.
  - LOAD: beat accepted when in_valid && in_ready.
    - The cycle after acceptance: load_en=1, load_address=index, load_value=in_value. Latency is 1 cycle.
    - index increments after each accepted beat.
    - When the accepted beat is index==tgt-1, go DONE.
    - Without an accepted beat, load_en=0 next cycle; load_address and load_value hold.
  - DONE: done=1 for one cycle, then IDLE. The final load_en and done are asserted in the same cycle.
- start in any state other than IDLE is ignored. start and abort together in IDLE: abort wins, nothing starts.
- abort=1 in CLEAR/LOAD/DONE -> IDLE next cycle.
  - No done pulse.
  - A beat presented in the abort cycle is not accepted (in_ready still high, but abort overrides): no write follows.
  - Writes already issued remain in the layer.
- Async reset mid-load: immediate return to IDLE. No write or done follows.
- load_address upper bits (SIZE-1 .. CNT_W) are always 0. The index never exceeds LAYER_SZ-1.
- layer_reset and load_en are never high in the same cycle.

Optional Feature:
Macro FC_LOAD_ZERO_SKIP_EN.
- Defined: an accepted beat with in_value==0 still advances index and counts toward tgt, but produces no load_en pulse. The layer was already cleared in CLEAR, so the result is identical. A zero final beat still yields done.
- Undefined: every accepted beat produces a load_en pulse.

Test Plan:
- num_values=3, beats 5,7,9 back-to-back.
  - layer_reset for 1 cycle.
  - Writes addr0=5, addr1=7, addr2=9 on consecutive cycles.
  - done coincident with the addr2 write, busy low the next cycle.
- num_values=4, in_valid toggled 1,0,0,1,1,0,1.
  - Exactly 4 writes to addresses 0..3 in order.
  - load_en low on the stall cycles; done once.
- num_values=0 -> CLEAR then DONE. No load_en, in_ready never high, done after 2 cycles.
- num_values=100 with LAYER_SZ=84 -> exactly 84 writes at addresses 0..83, then done.
- Abort after 2 of 5 beats (valid beat presented in the abort cycle) -> only addr0 and addr1 written, no done, IDLE next cycle. A new start is then honoured.
- Assert async reset between clock edges mid-LOAD -> outputs 0 immediately, no further writes.
- FC_LOAD_ZERO_SKIP_EN: beats 0,4,0 -> single write addr1=4, done still pulses. Without the macro, three writes.
